// File: rtl/cpu_ctrl_ws_pkg.sv
// Shared typedefs for the wait-state CPU control sequencer.
//   opcode_t : 3-bit instruction opcode
//   state_t  : 4-bit sequencer state (9 legal encodings, 9..15 illegal)
//   is_aluop : opcode reads an operand from memory and loads the accumulator
package cpu_ctrl_ws_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    localparam int WAIT_W = 4;

    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl_ws_wait.sv
// ctrl_wait_timer: decides when a read-wait point may advance.
//   clk, rst_ : clock, async active-low reset
//   i start   : load the down-counter (state is entering a wait point)
//   i active  : sequencer currently sits in a wait point
//   i ready   : memory read data valid (ready mode)
//   i mode    : 0 = fixed WAIT_CYC countdown, 1 = ready handshake
//   o done    : the wait point may advance on the next edge
module ctrl_wait_timer
    import cpu_ctrl_ws_pkg::*;
#(
    parameter int WAIT_CYC = 0
) (
    input  logic clk,
    input  logic rst_,
    input  logic start,
    input  logic active,
    input  logic ready,
    input  logic mode,
    output logic done
);

    logic [WAIT_W-1:0] r_cnt;

    // Counter holds the number of extra cycles still owed in this wait point.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            r_cnt <= '0;
        else if (start)
            r_cnt <= WAIT_W'(WAIT_CYC);
        else if (active && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign done = mode ? ready : (r_cnt == '0);

endmodule

// File: rtl/cpu_ctrl_ws.sv
// cpu_ctrl_ws: instruction sequencer with memory read wait states and halt.
//   clk, rst_        : clock, async active-low reset
//   opcode, zero     : current instruction and accumulator-zero flag
//   mem_ready        : read data valid (READY_MODE=1 only)
//   resume           : pulse that leaves HALTED
//   mem_rd..inc_pc   : datapath controls
//   halt, stall      : sequencer halted / holding on memory
//   instr_done       : pulse in STORE (the cycle before returning to INST_ADDR)
module cpu_ctrl_ws
    import cpu_ctrl_ws_pkg::*;
#(
    parameter int WAIT_CYC   = 0,
    parameter int READY_MODE = 0
) (
    input  logic    clk,
    input  logic    rst_,
    input  opcode_t opcode,
    input  logic    zero,
    input  logic    mem_ready,
    input  logic    resume,
    output logic    mem_rd,
    output logic    mem_wr,
    output logic    load_ir,
    output logic    load_ac,
    output logic    load_pc,
    output logic    inc_pc,
    output logic    halt,
    output logic    stall,
    output logic    instr_done
);

    state_t r_state;
    state_t w_next;
    logic   w_aluop;
    logic   w_wait_pt;
    logic   w_done;
    logic   w_stall;
    logic   w_start;

    assign w_aluop   = is_aluop(opcode);
    assign w_wait_pt = (r_state == INST_FETCH) || ((r_state == OP_FETCH) && w_aluop);
    assign w_stall   = w_wait_pt && !w_done;
    // Load the counter only on the edge that moves into a wait point, not while holding.
    assign w_start   = ((w_next == INST_FETCH) || ((w_next == OP_FETCH) && w_aluop))
                       && (w_next != r_state);

    ctrl_wait_timer #(.WAIT_CYC(WAIT_CYC)) u_wait (
        .clk    (clk),
        .rst_   (rst_),
        .start  (w_start),
        .active (w_wait_pt),
        .ready  (mem_ready),
        .mode   (READY_MODE != 0),
        .done   (w_done)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            r_state <= INST_ADDR;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            INST_ADDR:  w_next = INST_FETCH;
            INST_FETCH: w_next = w_stall ? INST_FETCH : INST_LOAD;
            INST_LOAD:  w_next = IDLE;
            IDLE:       w_next = OP_ADDR;
            OP_ADDR:    w_next = (opcode == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   w_next = w_stall ? OP_FETCH : ALU_OP;
            ALU_OP:     w_next = STORE;
            STORE:      w_next = INST_ADDR;
            HALTED:     w_next = resume ? OP_FETCH : HALTED;
            default:    w_next = INST_ADDR;
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        load_ir    = 1'b0;
        load_ac    = 1'b0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        halt       = 1'b0;
        stall      = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            INST_FETCH: begin
                mem_rd = 1'b1;
                stall  = w_stall;
            end
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR:  inc_pc = 1'b1;
            OP_FETCH: begin
                mem_rd = w_aluop;
                stall  = w_stall;
            end
            ALU_OP: begin
                mem_rd  = w_aluop;
                load_ac = w_aluop;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
            end
            STORE: begin
                mem_rd     = w_aluop;
                load_ac    = w_aluop;
                load_pc    = (opcode == JMP);
                inc_pc     = (opcode == JMP) || ((opcode == SKZ) && zero);
                mem_wr     = (opcode == STO);
                instr_done = 1'b1;
            end
            HALTED:   halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_ws.sv
// Randomized bench: three sequencers (fixed WAIT_CYC=0, fixed WAIT_CYC=3,
// ready handshake) driven with independent random inputs and checked every
// cycle against a stage-list model, with asynchronous resets injected mid-run.
module tb_cpu_ctrl_ws;
    import cpu_ctrl_ws_pkg::*;

    localparam int NDUT = 3;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    opcode_t          op [NDUT];
    logic [NDUT-1:0]  zero, mrdy, resume;
    logic [NDUT-1:0]  mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt, stall, idone;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cpu_ctrl_ws #(
            .WAIT_CYC   (g == 0 ? 0 : 3),
            .READY_MODE (g == 2 ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .rst_       (rst_),
            .opcode     (op[g]),
            .zero       (zero[g]),
            .mem_ready  (mrdy[g]),
            .resume     (resume[g]),
            .mem_rd     (mem_rd[g]),
            .mem_wr     (mem_wr[g]),
            .load_ir    (load_ir[g]),
            .load_ac    (load_ac[g]),
            .load_pc    (load_pc[g]),
            .inc_pc     (inc_pc[g]),
            .halt       (halt[g]),
            .stall      (stall[g]),
            .instr_done (idone[g])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b (rd wr ir ac pc inc halt stall done)", tag, got, exp);
    endtask

    function automatic logic [8:0] obs(input int k);
        return {mem_rd[k], mem_wr[k], load_ir[k], load_ac[k], load_pc[k],
                inc_pc[k], halt[k], stall[k], idone[k]};
    endfunction

    // Model: stage index 0..7 walks the instruction sequence, 8 = halted.
    int ph   [NDUT];
    int wrem [NDUT];

    function automatic int wcyc(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit alu(input int o);
        return (o >= 2) && (o <= 5);
    endfunction

    function automatic logic [8:0] expv(input int p, input int o, input bit z, input bit st);
        bit rd = 0, wr = 0, ir = 0, ac = 0, pc = 0, inc = 0, h = 0, dn = 0;
        case (p)
            1: rd = 1;
            2, 3: begin rd = 1; ir = 1; end
            4: inc = 1;
            5: rd = alu(o);
            6: begin rd = alu(o); ac = alu(o); inc = (o == 1) && z; pc = (o == 7); end
            7: begin
                rd = alu(o); ac = alu(o); pc = (o == 7);
                inc = (o == 7) || ((o == 1) && z); wr = (o == 6); dn = 1;
            end
            8: h = 1;
            default: ;
        endcase
        return {rd, wr, ir, ac, pc, inc, h, st, dn};
    endfunction

    function automatic bit mstall(input int k, input int o, input bit r);
        bit wp = (ph[k] == 1) || ((ph[k] == 5) && alu(o));
        return (k == 2) ? (wp && !r) : (wp && (wrem[k] > 0));
    endfunction

    task automatic step_model(input int k);
        int o = int'(op[k]);
        bit st = mstall(k, o, mrdy[k]);
        int np = ph[k];
        if (ph[k] == 8) begin
            if (resume[k]) np = 5;
        end else if ((ph[k] == 4) && (o == 0)) begin
            np = 8;
        end else if (st) begin
            if (k != 2) wrem[k]--;
        end else begin
            np = (ph[k] + 1) % 8;
        end
        if ((np != ph[k]) && ((np == 1) || ((np == 5) && alu(o)))) wrem[k] = wcyc(k);
        ph[k] = np;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            op[k] = ADD; zero[k] = 1'b0; mrdy[k] = 1'b0; resume[k] = 1'b0;
            ph[k] = 0; wrem[k] = 0;
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) chk($sformatf("reset_init[%0d]", k), obs(k), 9'b0);
        rst_ = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            for (int k = 0; k < NDUT; k++) begin
                if (ph[k] == 0) op[k] = opcode_t'($urandom_range(0, 7));
                zero[k]   = 1'($urandom);
                mrdy[k]   = ($urandom_range(0, 2) != 0);
                resume[k] = ($urandom_range(0, 4) == 0);
            end
            #1;
            for (int k = 0; k < NDUT; k++)
                chk($sformatf("cyc%0d[%0d] ph=%0d op=%0d", cyc, k, ph[k], int'(op[k])), obs(k),
                    expv(ph[k], int'(op[k]), zero[k], mstall(k, int'(op[k]), mrdy[k])));
            if ((cyc % 97) == 50) begin
                #1 rst_ = 1'b0;
                #1;
                for (int k = 0; k < NDUT; k++) begin
                    chk($sformatf("reset_mid cyc%0d[%0d]", cyc, k), obs(k), 9'b0);
                    ph[k] = 0; wrem[k] = 0;
                end
                #1 rst_ = 1'b1;
            end
            for (int k = 0; k < NDUT; k++) step_model(k);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_ws.md
CPU_CTRL_WS -- requirements
Module: cpu_ctrl_ws

Interface
REQ-001 Parameter WAIT_CYC, 0: extra read wait cycles in fixed mode, range 0..15.
REQ-002 Parameter READY_MODE, 0: 0 = fixed WAIT_CYC stall; 1 = stall on mem_ready handshake.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_  input  1  reset, asynchronous, active-low.
REQ-005 opcode  input  opcode_t (3)  current instruction opcode: HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP.
REQ-006 zero  input  1  accumulator-zero flag.
REQ-007 mem_ready  input  1  memory read data valid; used only when READY_MODE=1.
REQ-008 resume  input  1  single-cycle pulse that releases the halted state.
REQ-009 mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc  output  1 each  datapath controls.
REQ-010 halt  output  1  high for the whole time the sequencer is halted.
REQ-011 stall  output  1  high in any cycle the sequencer holds state waiting on memory.
REQ-012 instr_done  output  1  one-cycle pulse on the STORE -> INST_ADDR transition.

Function
REQ-013 States SHALL be INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED.
REQ-014 Base order SHALL be INST_ADDR->INST_FETCH->INST_LOAD->IDLE->OP_ADDR->OP_FETCH->ALU_OP->STORE->INST_ADDR, one state per cycle absent stalls.
REQ-015 aluop SHALL be 1 when opcode is ADD, AND, XOR or LDA.
REQ-016 Outputs per state: INST_FETCH mem_rd; INST_LOAD and IDLE mem_rd, load_ir; OP_ADDR inc_pc; OP_FETCH mem_rd=aluop; ALU_OP mem_rd=load_ac=aluop, inc_pc=(SKZ and zero), load_pc=JMP; STORE mem_rd=load_ac=aluop, load_pc=JMP, inc_pc=(JMP or (SKZ and zero)), mem_wr=STO; all others 0.
REQ-017 Read-wait points SHALL be INST_FETCH (always) and OP_FETCH (only when aluop=1).
REQ-018 Fixed mode: at a wait point the state SHALL hold for WAIT_CYC extra cycles via a down-counter loaded on entry; WAIT_CYC=0 gives no stall.
REQ-019 Ready mode: at a wait point the state SHALL hold until a cycle with mem_ready=1, advancing on the following edge; mem_ready outside wait points is ignored.
REQ-020 During a hold, stall=1 and the state's outputs SHALL remain asserted unchanged.
REQ-021 In OP_ADDR with opcode=HLT the next state SHALL be HALTED (inc_pc still asserted in OP_ADDR); halt=1 in HALTED, all datapath outputs 0.
REQ-022 HALTED SHALL exit to OP_FETCH on the edge after resume=1; resume in any other state is ignored.
REQ-023 resume asserted in the OP_ADDR cycle that enters HALTED SHALL be ignored; at least one HALTED cycle occurs.
REQ-024 Illegal state encodings SHALL return to INST_ADDR on the next edge with all outputs 0.
REQ-025 Instruction latency SHALL be 8 cycles plus stall cycles plus HALTED cycles.

Reset
REQ-026 rst_ low SHALL immediately force state INST_ADDR, wait counter 0, and all outputs 0, including in mid-stall or HALTED.
REQ-027 The first edge after rst_ deasserts SHALL move the state INST_ADDR->INST_FETCH.

Structure
REQ-028 opcode_t and the extended state_t (9 states, 4-bit) SHALL be in the shared typedefs package; WAIT_CYC and READY_MODE remain module parameters.
REQ-029 The wait logic SHALL be one sub-module, ctrl_wait_timer (start, ready, mode -> done), instantiated once.

Verification
REQ-030 WAIT_CYC=0, READY_MODE=0, opcode=ADD: instr_done every 8 cycles; load_ac high in ALU_OP and STORE.
REQ-031 WAIT_CYC=3, opcode=LDA: INST_FETCH and OP_FETCH each last 4 cycles with stall high 3 of them; instr_done every 14 cycles.
REQ-032 READY_MODE=1, mem_ready low 5 cycles in INST_FETCH: state holds 6 cycles, mem_rd steady; opcode=STO: OP_FETCH does not stall, mem_wr high in STORE only.
REQ-033 opcode=HLT: halt high from the cycle after OP_ADDR until resume; resume at cycle 10 -> OP_FETCH on the next edge.
REQ-034 opcode=SKZ, zero=1: inc_pc high in OP_ADDR, ALU_OP, STORE; zero=0: only in OP_ADDR.
REQ-035 rst_ pulsed low during a 3-cycle stall and again in HALTED: outputs 0 at once, restart from INST_ADDR, counter cleared.
